mod_engine: RTL and testbench
=============================

MOD_ENGINE -- requirements
Module: mod_engine

Interface
REQ-001 Parameter DATA_W, default 64: width of the payload on m_src and m_dst.
REQ-002 Port wb_clk_i, in, 1: the single clock.
REQ-003 Port wb_rst_i, in, 1: reset, asynchronous and active-high.
REQ-004 Port start, in, 1: one-cycle request to begin a transfer.
REQ-005 Port dc, in, 24: descriptor control; dc[1:0] selects the op (00 copy, 01 byte-swap, 10 invert, 11 zero-fill); dc[23:2] are ignored.
REQ-006 Port m_reset, out, 1: clears the channel FIFOs.
REQ-007 Ports m_src (in, 64), m_src_last (in, 1), m_src_empty (in, 1), m_src_almost_empty (in, 1), m_src_getn (out, 1, active-low pop).
REQ-008 Ports m_dst (out, 64), m_dst_last (out, 1), m_dst_putn (out, 1, active-low push), m_dst_full (in, 1), m_dst_almost_full (in, 1).
REQ-009 Port m_endn, out, 1: active-low end-of-stream indication to the channel.
REQ-010 Ports busy (out, 1), done (out, 1, one-cycle pulse), wcnt (out, 16): status.

Function
REQ-011 The FSM SHALL have the states IDLE, CLR, RUN, FLUSH and FIN.
REQ-012 From IDLE, start SHALL latch dc[1:0] into op_q and move to CLR; start in any other state SHALL be ignored.
REQ-013 CLR SHALL last exactly 1 cycle with m_reset=1, clear wcnt to 0, and move to RUN.
REQ-014 m_src SHALL be first-word-fall-through: data and m_src_last are valid whenever m_src_empty=0, and m_src_getn=0 pops that word.
REQ-015 In RUN, m_src_getn SHALL be 0 exactly when m_src_empty=0, m_dst_almost_full=0, and no last word has yet been popped; otherwise it SHALL be 1.
REQ-016 A popped word SHALL pass through the selected op and be registered, then presented on the next cycle with m_dst_putn=0 for exactly 1 cycle (latency 1).
REQ-017 Op rules: copy passes the word unchanged; byte-swap reverses the 8 bytes; invert is the bitwise NOT; zero-fill outputs 0; m_dst_last equals the popped m_src_last for every op.
REQ-018 Back-to-back pops SHALL give back-to-back pushes, one word per cycle while not throttled.
REQ-019 m_dst_almost_full is the throttle because it leaves room for the one word in flight; the engine SHALL never push while m_dst_full=1.
REQ-020 wcnt SHALL increment on each push and wrap from 0xFFFF to 0x0000.
REQ-021 Popping a word with m_src_last=1 SHALL move the FSM to FLUSH; FLUSH SHALL push that word, then move to FIN on the next cycle.
REQ-022 On entry to FIN, done SHALL pulse for 1 cycle, and m_endn SHALL be 0 from FIN until the next CLR completes (including while in IDLE).
REQ-023 FIN SHALL go to IDLE after 1 cycle.
REQ-024 busy SHALL be 1 in CLR, RUN and FLUSH, and 0 otherwise.
REQ-025 If m_src_empty=1 in RUN, the engine SHALL wait indefinitely with no timeout.
REQ-026 m_src_almost_empty is status only and SHALL NOT affect the pop decision.

Reset
REQ-027 Asserting wb_rst_i at any time, including mid-RUN, SHALL immediately force: state IDLE, m_src_getn=1, m_dst_putn=1, m_reset=0, m_endn=1, m_dst=0, m_dst_last=0, busy=0, done=0, wcnt=0, op_q=00.
REQ-028 No push SHALL occur in the first cycle after reset is released.

Structure
REQ-029 A shared package SHALL hold the state encoding, the op codes (OP_COPY, OP_BSWAP, OP_INV, OP_ZERO) and the field position dc[1:0].
REQ-030 The combinational data transform SHALL be one sub-module, mod_op_xform, with inputs op and din[63:0] and output dout[63:0].
REQ-031 The FSM, pop logic, output register and counter SHALL live in mod_engine; the target size is 150-250 lines.

Verification
REQ-032 Copy: op=00, 4 words 0x0..01..0x0..04 with last on word 4 -> 4 pushes 1 cycle after each pop, m_dst_last only on the 4th, done pulses once, wcnt=4, m_endn=0.
REQ-033 Byte-swap: op=01, one word 0x0102030405060708 with last -> m_dst=0x0807060504030201 and m_dst_last=1.
REQ-034 Throttle: hold m_dst_almost_full=1 for 5 cycles mid-stream -> no pops during those cycles, no push while m_dst_full=1, and no words lost or duplicated.
REQ-035 Empty stall: src stays empty for 10 cycles after CLR -> getn=1, putn=1, busy=1; data then arriving is processed normally.
REQ-036 Reset mid-RUN after 2 pushes -> all outputs at reset values next edge; a new start then gives a 1-cycle m_reset pulse, wcnt=0, and m_endn=1 after CLR.
REQ-037 start asserted while busy -> ignored, op_q unchanged, and exactly one done pulse per accepted start.

Source files
------------

// File: rtl/mod_engine_pkg.sv
// Shared definitions for the descriptor-driven word transform engine:
// FSM state encoding, op codes and where the op lives in the descriptor.
package mod_engine_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        RUN   = 3'd2,
        FLUSH = 3'd3,
        FIN   = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        OP_COPY  = 2'b00,
        OP_BSWAP = 2'b01,
        OP_INV   = 2'b10,
        OP_ZERO  = 2'b11
    } op_t;

    localparam int DC_W      = 24;
    localparam int DC_OP_LSB = 0;
    localparam int DC_OP_MSB = 1;

    // Extract the op field from a descriptor control word.
    function automatic op_t dc_op(input logic [DC_OP_MSB:DC_OP_LSB] op_bits);
        return op_t'(op_bits);
    endfunction

endpackage

// File: rtl/mod_engine_op_xform.sv
// Purely combinational word transform: copy, byte reversal, bitwise
// inversion or zero-fill, selected by op.
module mod_op_xform
    import mod_engine_pkg::*;
#(
    parameter int W = 64
) (
    input  op_t          op,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    localparam int NBYTES = W / 8;

    logic [W-1:0] bswap;

    // Byte lane gi of the output takes the mirrored byte lane of the input.
    generate
        for (genvar gi = 0; gi < NBYTES; gi++) begin : g_bswap
            assign bswap[gi*8 +: 8] = din[(NBYTES-1-gi)*8 +: 8];
        end
    endgenerate

    // Select the transformed word for the latched op.
    always_comb begin
        dout = din;
        case (op)
            OP_COPY:  dout = din;
            OP_BSWAP: dout = bswap;
            OP_INV:   dout = ~din;
            OP_ZERO:  dout = '0;
            default:  dout = din;
        endcase
    end

endmodule

// File: rtl/mod_engine.sv
// Stream engine: on start, clears the channel FIFOs, then moves words from a
// first-word-fall-through source FIFO through a selectable transform into a
// destination FIFO until a word marked last has been written.
module mod_engine
    import mod_engine_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              start,
    input  logic [DC_W-1:0]   dc,
    output logic              m_reset,
    input  logic [DATA_W-1:0] m_src,
    input  logic              m_src_last,
    input  logic              m_src_empty,
    input  logic              m_src_almost_empty,
    output logic              m_src_getn,
    output logic [DATA_W-1:0] m_dst,
    output logic              m_dst_last,
    output logic              m_dst_putn,
    input  logic              m_dst_full,
    input  logic              m_dst_almost_full,
    output logic              m_endn,
    output logic              busy,
    output logic              done,
    output logic [15:0]       wcnt
);

    state_t            state_reg;
    op_t               op_q;
    logic              pop;
    logic [DATA_W-1:0] xform_word;
    logic              status_unused;

    // The upper descriptor bits, the almost-empty flag and the full flag
    // carry no decision weight: almost-full already reserves room for the
    // single word in flight, so full can never be hit by a push.
    assign status_unused = ^{dc[DC_W-1:DC_OP_MSB+1], m_src_almost_empty, m_dst_full};

    // A word is popped only in RUN; once the last word is popped the FSM
    // leaves RUN, so no further pops can follow it.
    assign pop        = (state_reg == RUN) && !m_src_empty && !m_dst_almost_full;
    assign m_src_getn = ~pop;

    mod_op_xform #(
        .W (DATA_W)
    ) u_xform (
        .op   (op_q),
        .din  (m_src),
        .dout (xform_word)
    );

    // Control FSM with registered status and channel-control outputs.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_reg <= IDLE;
            op_q      <= OP_COPY;
            m_reset   <= 1'b0;
            m_endn    <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        op_q      <= dc_op(dc[DC_OP_MSB:DC_OP_LSB]);
                        m_reset   <= 1'b1;
                        busy      <= 1'b1;
                        state_reg <= CLR;
                    end
                end
                CLR: begin
                    // End-of-stream stays asserted until the clear completes.
                    m_reset   <= 1'b0;
                    m_endn    <= 1'b1;
                    state_reg <= RUN;
                end
                RUN: begin
                    if (pop && m_src_last) begin
                        state_reg <= FLUSH;
                    end
                end
                FLUSH: begin
                    // The last word is being pushed this cycle.
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    m_endn    <= 1'b0;
                    state_reg <= FIN;
                end
                FIN: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Output word register, push strobe and word counter; a pop now is a
    // push presented on the following cycle.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            m_dst      <= '0;
            m_dst_last <= 1'b0;
            m_dst_putn <= 1'b1;
            wcnt       <= 16'd0;
        end else begin
            m_dst_putn <= ~pop;
            if (pop) begin
                m_dst      <= xform_word;
                m_dst_last <= m_src_last;
                wcnt       <= wcnt + 16'd1;
            end else if (state_reg == CLR) begin
                wcnt <= 16'd0;
            end
        end
    end

endmodule

// File: tb/tb_mod_engine.sv
// Directed bench for mod_engine: a FWFT source model feeds words, expected
// output words are queued at load time and a monitor compares every push.
module tb_mod_engine;

    typedef struct {
        logic [63:0] data;
        logic        last;
    } word_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [23:0] dc;
    logic        m_reset;
    logic [63:0] m_src;
    logic        m_src_last;
    logic        m_src_empty;
    logic        m_src_almost_empty;
    logic        m_src_getn;
    logic [63:0] m_dst;
    logic        m_dst_last;
    logic        m_dst_putn;
    logic        m_dst_full;
    logic        m_dst_almost_full;
    logic        m_endn;
    logic        busy;
    logic        done;
    logic [15:0] wcnt;

    word_t src_q[$];
    word_t exp_q[$];

    int checks_total  = 0;
    int checks_passed = 0;
    int done_cnt      = 0;
    int push_cnt      = 0;

    mod_engine #(
        .DATA_W (64)
    ) dut (
        .wb_clk_i           (clk),
        .wb_rst_i           (rst),
        .start              (start),
        .dc                 (dc),
        .m_reset            (m_reset),
        .m_src              (m_src),
        .m_src_last         (m_src_last),
        .m_src_empty        (m_src_empty),
        .m_src_almost_empty (m_src_almost_empty),
        .m_src_getn         (m_src_getn),
        .m_dst              (m_dst),
        .m_dst_last         (m_dst_last),
        .m_dst_putn         (m_dst_putn),
        .m_dst_full         (m_dst_full),
        .m_dst_almost_full  (m_dst_almost_full),
        .m_endn             (m_endn),
        .busy               (busy),
        .done               (done),
        .wcnt               (wcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            checks_passed++;
        end
    endtask

    // Main-process drive/check point: just after the active edge, after the
    // source model has updated its outputs.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic load(input logic [63:0] d, input logic l, input logic [63:0] e);
        word_t w;
        w.data = d;
        w.last = l;
        src_q.push_back(w);
        w.data = e;
        exp_q.push_back(w);
    endtask

    // Issue a start and check the one-cycle clear that follows it.
    task automatic start_op(input logic [1:0] op);
        tick();
        start = 1'b1;
        dc    = {22'h2AAAAA, op};
        tick();
        start = 1'b0;
        check("clr_m_reset", {63'd0, m_reset}, 64'd1);
        check("clr_busy", {63'd0, busy}, 64'd1);
        tick();
        check("run_m_reset", {63'd0, m_reset}, 64'd0);
        check("run_m_endn", {63'd0, m_endn}, 64'd1);
        check("run_wcnt", {48'd0, wcnt}, 64'd0);
    endtask

    // Wait for the done pulse, then check the end-of-stream state.
    task automatic wait_done(input int budget, input logic [15:0] exp_wcnt, input int done_before);
        bit seen = 0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (done) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            check("done_timeout", 64'd0, 64'd1);
        end else begin
            check("fin_wcnt", {48'd0, wcnt}, {48'd0, exp_wcnt});
            check("fin_m_endn", {63'd0, m_endn}, 64'd0);
            check("fin_busy", {63'd0, busy}, 64'd0);
            tick();
            check("idle_m_endn", {63'd0, m_endn}, 64'd0);
            check("done_pulses", done_cnt, done_before + 1);
            check("all_words_out", exp_q.size(), 64'd0);
        end
    endtask

    // FWFT source FIFO model: pops on the edge after getn was seen low.
    initial begin
        bit do_pop;
        m_src              = '0;
        m_src_last         = 1'b0;
        m_src_empty        = 1'b1;
        m_src_almost_empty = 1'b1;
        forever begin
            @(negedge clk);
            do_pop = !m_src_getn && !m_src_empty && !rst;
            @(posedge clk);
            #1;
            if (do_pop && src_q.size() > 0) void'(src_q.pop_front());
            if (src_q.size() > 0) begin
                m_src       = src_q[0].data;
                m_src_last  = src_q[0].last;
                m_src_empty = 1'b0;
            end else begin
                m_src       = '0;
                m_src_last  = 1'b0;
                m_src_empty = 1'b1;
            end
            m_src_almost_empty = (src_q.size() < 2);
        end
    end

    // Monitor: compares each push against the scoreboard and checks the
    // pop/push timing rules.
    initial begin
        bit prev_pop = 0;
        word_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_pop = 0;
                continue;
            end
            if (done) done_cnt++;
            if (!m_dst_putn) begin
                push_cnt++;
                check("full_at_push", {63'd0, m_dst_full}, 64'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_push", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("dst_data", m_dst, e.data);
                    check("dst_last", {63'd0, m_dst_last}, {63'd0, e.last});
                end
            end
            if (prev_pop || !m_dst_putn) check("push_latency", {63'd0, m_dst_putn}, {63'd0, !prev_pop});
            if (m_dst_almost_full) check("pop_while_af", {63'd0, m_src_getn}, 64'd1);
            prev_pop = !m_src_getn;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int dbase;
        bit got;
        rst               = 1'b1;
        start             = 1'b0;
        dc                = '0;
        m_dst_full        = 1'b0;
        m_dst_almost_full = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_getn", {63'd0, m_src_getn}, 64'd1);
        check("rst_putn", {63'd0, m_dst_putn}, 64'd1);
        check("rst_m_reset", {63'd0, m_reset}, 64'd0);
        check("rst_m_endn", {63'd0, m_endn}, 64'd1);
        check("rst_m_dst", m_dst, 64'd0);
        check("rst_m_dst_last", {63'd0, m_dst_last}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_wcnt", {48'd0, wcnt}, 64'd0);
        rst = 1'b0;
        tick();
        check("no_push_after_reset", {63'd0, m_dst_putn}, 64'd1);

        // Copy: four words, last on the fourth
        load(64'h1, 1'b0, 64'h1);
        load(64'h2, 1'b0, 64'h2);
        load(64'h3, 1'b0, 64'h3);
        load(64'h4, 1'b1, 64'h4);
        dbase = done_cnt;
        start_op(2'b00);
        wait_done(60, 16'd4, dbase);

        // Byte-swap
        load(64'h0102030405060708, 1'b1, 64'h0807060504030201);
        dbase = done_cnt;
        start_op(2'b01);
        wait_done(60, 16'd1, dbase);

        // Invert
        load(64'h00000000FFFFFFFF, 1'b0, 64'hFFFFFFFF00000000);
        load(64'h0123456789ABCDEF, 1'b1, 64'hFEDCBA9876543210);
        dbase = done_cnt;
        start_op(2'b10);
        wait_done(60, 16'd2, dbase);

        // Zero-fill
        load(64'hDEADBEEFCAFEF00D, 1'b1, 64'h0);
        dbase = done_cnt;
        start_op(2'b11);
        wait_done(60, 16'd1, dbase);

        // Throttle: almost-full for 5 cycles mid-stream, full inside it
        for (int i = 0; i < 8; i++) load(64'h10 + 64'(i), (i == 7), 64'h10 + 64'(i));
        dbase = done_cnt;
        start_op(2'b00);
        tick();
        m_dst_almost_full = 1'b1;
        tick();
        tick();
        m_dst_full = 1'b1;
        tick();
        tick();
        m_dst_full = 1'b0;
        tick();
        m_dst_almost_full = 1'b0;
        wait_done(60, 16'd8, dbase);

        // Empty stall after CLR, then data arrives
        dbase = done_cnt;
        start_op(2'b00);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("stall_getn", {63'd0, m_src_getn}, 64'd1);
            check("stall_putn", {63'd0, m_dst_putn}, 64'd1);
            check("stall_busy", {63'd0, busy}, 64'd1);
        end
        load(64'h5555AAAA5555AAAA, 1'b0, 64'h5555AAAA5555AAAA);
        load(64'h0F0F0F0F0F0F0F0F, 1'b1, 64'h0F0F0F0F0F0F0F0F);
        wait_done(60, 16'd2, dbase);

        // Reset mid-RUN after two pushes
        for (int i = 0; i < 6; i++) load(64'h100 + 64'(i), (i == 5), 64'h100 + 64'(i));
        base = push_cnt;
        start_op(2'b00);
        got = 0;
        for (int i = 0; i < 20; i++) begin
            if (push_cnt >= base + 2) begin
                got = 1;
                break;
            end
            @(negedge clk);
            #1;
        end
        if (!got) check("two_push_timeout", 64'd0, 64'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_getn", {63'd0, m_src_getn}, 64'd1);
        check("mid_rst_putn", {63'd0, m_dst_putn}, 64'd1);
        check("mid_rst_m_reset", {63'd0, m_reset}, 64'd0);
        check("mid_rst_m_endn", {63'd0, m_endn}, 64'd1);
        check("mid_rst_m_dst", m_dst, 64'd0);
        check("mid_rst_m_dst_last", {63'd0, m_dst_last}, 64'd0);
        check("mid_rst_busy", {63'd0, busy}, 64'd0);
        check("mid_rst_done", {63'd0, done}, 64'd0);
        check("mid_rst_wcnt", {48'd0, wcnt}, 64'd0);
        src_q.delete();
        exp_q.delete();
        tick();
        tick();
        rst = 1'b0;
        tick();
        load(64'hCAFE, 1'b1, 64'hCAFE);
        dbase = done_cnt;
        start_op(2'b00);
        wait_done(60, 16'd1, dbase);

        // start while busy is ignored; op stays copy
        load(64'h1111111111111111, 1'b0, 64'h1111111111111111);
        dbase = done_cnt;
        start_op(2'b00);
        tick();
        start = 1'b1;
        dc    = {22'h0, 2'b10};
        tick();
        tick();
        start = 1'b0;
        check("busy_start_busy", {63'd0, busy}, 64'd1);
        load(64'h2222222222222222, 1'b1, 64'h2222222222222222);
        wait_done(60, 16'd2, dbase);
        repeat (10) tick();
        check("single_done", done_cnt, dbase + 1);
        check("idle_after_done", {63'd0, busy}, 64'd0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
